xeng_window_ctrl: RTL

XENG_WINDOW_CTRL -- requirements
Module: xeng_window_ctrl

---
 rtl/xeng_window_if.sv | 26 ++
 rtl/xeng_window_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/xeng_window_if.sv
// xeng_window_if: buffer-read and X-engine output signals of the window controller
interface xeng_window_if #(
  parameter int MCNT_WIDTH = 48,
  parameter int IW = 64
);
  logic arm;
  logic [MCNT_WIDTH-1:0] mcnt_start;
  logic buf_win_avail;
  logic buf_rd_en;
  logic [IW-1:0] buf_rd_data;
  logic xeng_sync_in;
  logic [IW-1:0] xeng_din;
  logic xeng_vld;
  logic [MCNT_WIDTH-1:0] xeng_mcnt;
  logic win_done;
  logic [31:0] win_cnt;
  logic busy;
  modport slave (
    input arm, mcnt_start, buf_win_avail, buf_rd_data,
    output buf_rd_en, xeng_sync_in, xeng_din, xeng_vld, xeng_mcnt, win_done, win_cnt, busy
  );
  modport master (
    output arm, mcnt_start, buf_win_avail, buf_rd_data,
    input buf_rd_en, xeng_sync_in, xeng_din, xeng_vld, xeng_mcnt, win_done, win_cnt, busy
  );
endinterface

// File: rtl/xeng_window_ctrl.sv
// xeng_window_ctrl: issues whole accumulation windows from the upstream buffer to the X-engine
module xeng_window_ctrl #(
  parameter int N_ANTS = 32,
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int P_FACTOR_BITS = 2,
  parameter int BITWIDTH = 4,
  parameter int MCNT_WIDTH = 48,
  parameter int RD_LATENCY = 2
) (
  input logic clk,
  input logic rst_n,
  xeng_window_if.slave bus
);
  localparam int IW = 2 * BITWIDTH * 2 * (1 << P_FACTOR_BITS);
  localparam int WIN_LEN = N_ANTS << SERIAL_ACC_LEN_BITS;
  localparam int CW = $clog2(WIN_LEN);
  typedef enum logic [1:0] {IDLE, SYNC, WAIT, RUN} state_e;
  typedef struct packed {logic sync; logic rd; logic first; logic last;} tok_t;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MCNT_WIDTH-1:0] mcnt_q, mcnt_d, xmcnt_q;
  tok_t tok, tail;
  tok_t [RD_LATENCY-1:0] dl_q;
  logic vld_q, sync_q, done_q;
  logic [IW-1:0] din_q;
  logic [31:0] wcnt_q;
  logic last, go;
  assign last = cnt_q == CW'(WIN_LEN - 1);
  assign go = bus.arm && bus.buf_win_avail;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcnt_q <= mcnt_d;
    end
  end
  // SYNC skips WAIT when a window is already available so vld follows sync by one cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mcnt_d = mcnt_q;
    case (state_q)
      IDLE: begin
        state_d = bus.arm ? SYNC : IDLE;
        mcnt_d = bus.arm ? bus.mcnt_start : mcnt_q;
      end
      SYNC: state_d = go ? RUN : WAIT;
      WAIT: state_d = go ? RUN : bus.arm ? WAIT : IDLE;
      RUN: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        state_d = !last ? RUN : go ? RUN : bus.arm ? WAIT : IDLE;
        mcnt_d = (last && bus.arm) ? mcnt_q + 1'b1 : mcnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tok.sync = state_q == SYNC;
    tok.rd = state_q == RUN;
    tok.first = state_q == RUN && cnt_q == '0;
    tok.last = state_q == RUN && last;
    bus.buf_rd_en = state_q == RUN;
  end
  assign tail = dl_q[RD_LATENCY-1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_q <= '0;
      vld_q <= 1'b0;
      sync_q <= 1'b0;
      done_q <= 1'b0;
      din_q <= '0;
      xmcnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      dl_q[0] <= tok;
      for (int i = 1; i < RD_LATENCY; i++) dl_q[i] <= dl_q[i-1];
      vld_q <= tail.rd;
      sync_q <= tail.sync;
      done_q <= tail.last;
      din_q <= tail.rd ? bus.buf_rd_data : din_q;
      xmcnt_q <= tail.first ? mcnt_q : xmcnt_q;
      wcnt_q <= wcnt_q + {31'd0, done_q};
    end
  end
  assign bus.xeng_sync_in = sync_q;
  assign bus.xeng_vld = vld_q;
  assign bus.win_done = done_q;
  assign bus.xeng_din = din_q;
  assign bus.xeng_mcnt = xmcnt_q;
  assign bus.win_cnt = wcnt_q;
  assign bus.busy = state_q != IDLE || |dl_q || vld_q || sync_q;
endmodule
